// File: rtl/parity_serial_rx.sv
// Purpose: deserialises start/data/parity/stop frames, checks parity (even/odd) and stop bit, holds the word until acked.
// Latency: the word is published the cycle after the stop-bit sample, HALF+(DATA_W+2)*CLKS_PER_BIT cycles after START is entered.
// Backpressure: none on the line; a new word overwrites an unacked one and sets sticky overrun.
module parity_serial_rx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic              rx_serial,
  input  logic              rx_ack,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     bit_idx;
  logic [DATA_W-1:0] shift_q;
  logic              mode_q;
  logic              p_q;
  logic              rx_s1;
  logic              rxs;
  logic              pub;
  logic              exp_par;

  // Publish strobe at the stop-bit mid-point, and the parity bit the frame should have carried.
  always_comb begin
    pub     = (state == S_STOP) && (cnt == CNT_LAST);
    exp_par = mode_q ? ~^shift_q : ^shift_q;
  end

  // Line synchroniser, frame FSM, and consumer handshake with overrun tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1      <= 1'b1;
      rxs        <= 1'b1;
      state      <= S_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift_q    <= '0;
      mode_q     <= 1'b0;
      p_q        <= 1'b0;
      busy       <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_s1 <= rx_serial;
      rxs   <= rx_s1;

      case (state)
        S_IDLE: begin
          if (!rxs) begin
            state  <= S_START;
            cnt    <= '0;
            mode_q <= mode;
            busy   <= 1'b1;
          end
        end
        S_START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (!rxs) begin
              state   <= S_DATA;
              bit_idx <= '0;
            end else begin
              // Start bit gone by its mid-point: treat as a glitch.
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt              <= '0;
            shift_q[bit_idx] <= rxs;
            if (bit_idx == BIT_LAST) state <= S_PARITY;
            else                     bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            p_q   <= rxs;
            state <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase

      // Word and flags always load together; errored frames are still delivered.
      if (pub) begin
        rx_data    <= shift_q;
        parity_err <= (p_q != exp_par);
        frame_err  <= ~rxs;
        rx_valid   <= 1'b1;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end

      // An ack coinciding with a publish consumes the old word, so no overrun.
      if (pub && rx_valid && !rx_ack) overrun <= 1'b1;
      else if (rx_ack && rx_valid)    overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_parity_serial_rx.sv
// Purpose: directed checks of parity_serial_rx with hand-computed expected words and flags.
// Latency: expects rx_valid 171 cycles after the start edge (2 sync + HALF + 10 bits + 1).
// Backpressure: exercises ack, overrun, and ack coincident with publish.
module tb_parity_serial_rx;

  localparam int DATA_W = 8;
  localparam int CPB    = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              mode = 1'b0;
  logic              rx_serial = 1'b1;
  logic              rx_ack = 1'b0;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              parity_err;
  logic              frame_err;
  logic              overrun;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int vld_cyc;
  int busy_seen;

  parity_serial_rx #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .rx_serial  (rx_serial),
    .rx_ack     (rx_ack),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Drives one full frame starting on a negedge; records the first cycle rx_valid is seen.
  // ack_at / tog_at: cycle index at which to pulse rx_ack / toggle mode (-1 = never).
  task automatic send(input logic [7:0] d, input logic p, input logic stop,
                      input int ack_at, input int tog_at);
    logic [10:0] fr;
    int k;
    fr = {stop, p, d, 1'b0};
    k = 0;
    vld_cyc = -1;
    for (int b = 0; b < 11; b++) begin
      rx_serial = fr[b];
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        k++;
        if (rx_valid && vld_cyc < 0) vld_cyc = k;
        rx_ack = (k == ack_at);
        if (k == tog_at) mode = ~mode;
      end
    end
    rx_ack = 1'b0;
    rx_serial = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic ack_once();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_valid", rx_valid, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_outs", {rx_data, rx_valid, parity_err, frame_err, overrun, busy}, 0);

    // Even parity 0xA5 (four ones -> p=0), latency and ack.
    mode = 1'b0;
    send(8'hA5, 1'b0, 1'b1, -1, -1);
    check("even_lat", vld_cyc, 171);
    check("even_data", rx_data, 8'hA5);
    check("even_flags", {rx_valid, parity_err, frame_err, overrun}, 4'b1000);
    ack_once();
    check("even_ack_vld", rx_valid, 0);
    check("even_keep_data", rx_data, 8'hA5);

    // Odd parity 0x3C (four ones -> p=1 good, p=0 bad).
    mode = 1'b1;
    send(8'h3C, 1'b1, 1'b1, -1, -1);
    check("odd_ok_perr", parity_err, 0);
    check("odd_ok_vld", rx_valid, 1);
    ack_once();
    send(8'h3C, 1'b0, 1'b1, -1, -1);
    check("odd_bad_perr", parity_err, 1);
    check("odd_bad_data", rx_data, 8'h3C);
    ack_once();
    check("ack_keeps_perr", parity_err, 1);

    // Framing error 0x81 even parity p=0, stop=0.
    mode = 1'b0;
    send(8'h81, 1'b0, 1'b0, -1, -1);
    check("ferr_flag", frame_err, 1);
    check("ferr_perr", parity_err, 0);
    check("ferr_data", rx_data, 8'h81);
    ack_once();

    // 3-cycle glitch: busy pulses, nothing published.
    busy_seen = 0;
    rx_serial = 1'b0;
    repeat (3) @(negedge clk);
    rx_serial = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) busy_seen = 1;
      if (rx_valid) vld_cyc = 1;
    end
    check("glitch_busy_seen", busy_seen, 1);
    check("glitch_busy_end", busy, 0);
    check("glitch_no_vld", rx_valid, 0);

    // Overrun: two frames without ack.
    send(8'h11, 1'b0, 1'b1, -1, -1);
    check("ovr_first_ovr", overrun, 0);
    send(8'h22, 1'b0, 1'b1, -1, -1);
    check("ovr_data", rx_data, 8'h22);
    check("ovr_set", {rx_valid, overrun}, 2'b11);
    ack_once();
    check("ovr_clr", {rx_valid, overrun}, 2'b00);

    // Ack coincident with the second publish (sampled at edge 171).
    send(8'h11, 1'b0, 1'b1, -1, -1);
    send(8'h22, 1'b0, 1'b1, 170, -1);
    check("coin_vld_ovr", {rx_valid, overrun}, 2'b10);
    check("coin_data", rx_data, 8'h22);
    ack_once();

    // Mode latched at start: even frame 0x3C p=0, mode flipped mid-frame.
    mode = 1'b0;
    send(8'h3C, 1'b0, 1'b1, -1, 40);
    check("mode_latch_perr", parity_err, 0);
    check("mode_latch_vld", rx_valid, 1);
    ack_once();
    mode = 1'b0;

    // Line stuck low: zero word with framing error.
    rx_serial = 1'b0;
    repeat (180) @(negedge clk);
    check("low_vld", rx_valid, 1);
    check("low_ferr", frame_err, 1);
    check("low_data", rx_data, 0);
    rx_serial = 1'b1;
    repeat (200) @(negedge clk);
    ack_once();

    // Reset in the middle of DATA with a held word: everything clears, nothing appears.
    send(8'h5A, 1'b0, 1'b1, -1, -1);
    rx_serial = 1'b0;
    repeat (16) @(negedge clk);
    rx_serial = 1'b1;
    repeat (30) @(negedge clk);
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_outs", {rx_data, rx_valid, parity_err, frame_err, overrun, busy}, 0);
    rst_n = 1'b1;
    vld_cyc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rx_valid && vld_cyc < 0) vld_cyc = i;
    end
    check("mid_no_vld", vld_cyc, -1);
    check("mid_busy_end", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
